// File: rtl/d_fifo_pkg.sv
// Shared defaults and helpers for the d_fifo buffer.
// The occupancy helper turns a push/pop pair into a single count action.
package d_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 32;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_change_t;

  // A simultaneous push and pop leaves occupancy unchanged.
  function automatic occ_change_t occ_change(input logic push, input logic pop);
    occ_change_t result;
    result = OCC_HOLD;
    if (push && !pop) result = OCC_INC;
    else if (pop && !push) result = OCC_DEC;
    return result;
  endfunction

endpackage

// File: rtl/d_fifo_ctrl.sv
// Pointer, occupancy and handshake control for d_fifo.
// Flags are derived combinationally from the registered count.
module d_fifo_ctrl
  import d_fifo_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  din_v,
  input  logic                  dout_r,
  output logic                  push,
  output logic                  pop,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic                  din_r,
  output logic                  dout_v
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH:0] count;
  occ_change_t         change;

  assign din_r  = (count != FULL_COUNT);
  assign dout_v = (count != '0);
  assign push   = din_v & din_r;
  assign pop    = dout_v & dout_r;

  always_comb begin
    change = OCC_HOLD;
    change = occ_change(push, pop);
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      unique case (change)
        OCC_INC: count <= count + (ADDR_WIDTH + 1)'(1);
        OCC_DEC: count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/d_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Storage lives here; pointers and flags live in d_fifo_ctrl.
module d_fifo
  import d_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_din,
  input  logic                  io_din_v,
  output logic                  io_din_r,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_dout_v,
  input  logic                  io_dout_r
);

  logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  d_fifo_ctrl #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) ctrl (
    .clock  (clock),
    .reset  (reset),
    .din_v  (io_din_v),
    .dout_r (io_dout_r),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .din_r  (io_din_r),
    .dout_v (io_dout_v)
  );

  // Storage is deliberately left out of reset; emptiness is tracked by the count.
  always_ff @(posedge clock) begin
    if (push) memory[wr_ptr] <= io_din;
  end

  always_comb begin
    io_dout = '0;
    if (io_dout_v) io_dout = memory[rd_ptr];
  end

endmodule

// File: tb/tb_d_fifo.sv
// Self-checking bench for d_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_d_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          clock;
  logic          reset;
  logic [DW-1:0] io_din;
  logic          io_din_v;
  logic          io_din_r;
  logic [DW-1:0] io_dout;
  logic          io_dout_v;
  logic          io_dout_r;

  int            checks;
  int            errors;
  logic [DW-1:0] model_q[$];

  d_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .io_din    (io_din),
    .io_din_v  (io_din_v),
    .io_din_r  (io_din_r),
    .io_dout   (io_dout),
    .io_dout_v (io_dout_v),
    .io_dout_r (io_dout_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag);
    logic          exp_din_r;
    logic          exp_dout_v;
    logic [DW-1:0] exp_dout;
    exp_din_r  = (model_q.size() != DEPTH);
    exp_dout_v = (model_q.size() != 0);
    exp_dout   = exp_dout_v ? model_q[0] : '0;
    checks++;
    assert (io_din_r === exp_din_r)
      else begin errors++; $error("FAIL %s din_r observed %b expected %b", tag, io_din_r, exp_din_r); end
    checks++;
    assert (io_dout_v === exp_dout_v)
      else begin errors++; $error("FAIL %s dout_v observed %b expected %b", tag, io_dout_v, exp_dout_v); end
    checks++;
    assert (io_dout === exp_dout)
      else begin errors++; $error("FAIL %s dout observed %0d expected %0d", tag, io_dout, exp_dout); end
  endtask

  // One clock: the model decides acceptance from its own occupancy before the edge.
  task automatic tick(input string tag);
    logic          will_push;
    logic          will_pop;
    logic [DW-1:0] word;
    will_push = reset && io_din_v && (model_q.size() < DEPTH);
    will_pop  = reset && io_dout_r && (model_q.size() > 0);
    word      = io_din;
    @(posedge clock);
    #1;
    if (!reset) model_q.delete();
    else begin
      if (will_pop)  void'(model_q.pop_front());
      if (will_push) model_q.push_back(word);
    end
    check_output(tag);
  endtask

  task automatic apply_stimulus(input logic v, input logic [DW-1:0] d, input logic r);
    io_din_v  = v;
    io_din    = d;
    io_dout_r = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    apply_stimulus(1'b0, '0, 1'b0);

    // Reset
    reset = 1'b0;
    tick("reset");
    #3 reset = 1'b1;
    tick("post_reset");

    // Streaming 1,3,5,7,9 with consumer always ready
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, DW'(2 * i + 1), 1'b1);
      tick("stream");
    end
    apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) tick("stream_tail");

    // Fill to full, reject 99, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, DW'(i), 1'b0);
      tick("fill");
    end
    apply_stimulus(1'b1, DW'(99), 1'b0);
    tick("reject_99");
    apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) tick("drain");

    // Wrap-around at an occupancy of about four
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, DW'(i * 2), 1'b0);
      tick("wrap_prime");
    end
    for (int i = 4; i < 40; i++) begin
      apply_stimulus(1'b1, DW'(i * 2), 1'b1);
      tick("wrap_steady");
    end
    apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) tick("wrap_drain");

    // Full with simultaneous push and pop: only the pop happens
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b1, DW'(100 + i), 1'b0);
      tick("full_fill");
    end
    apply_stimulus(1'b1, DW'(77), 1'b1);
    tick("full_push_pop");
    tick("full_accept_77");
    apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) tick("full_drain");

    // Mid-stream reset discards queued words immediately
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, DW'(200 + i), 1'b0);
      tick("pre_reset");
    end
    apply_stimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
    #1;
    model_q.delete();
    check_output("async_reset");
    tick("in_reset");
    #3 reset = 1'b1;
    apply_stimulus(1'b1, DW'(5), 1'b0);
    tick("after_reset_push");
    apply_stimulus(1'b0, '0, 1'b1);
    tick("after_reset_pop");

    // Random traffic, alternating producer-heavy and consumer-heavy phases
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 75) % 2 == 0) ? 80 : 30;
      apply_stimulus(($urandom_range(99) < bias), DW'($urandom),
                     ($urandom_range(99) >= bias));
      tick("random");
    end
    apply_stimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) tick("random_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
